piso_bidir_serializer: RTL
==========================

Name: piso_bidir_serializer

Overview:
Parallel-in, serial-out transmitter. It is the sending end of the team's serial-in bidirectional shift-register receiver. It accepts an n-bit word through a valid/ready handshake, together with a per-word direction. It then emits the word one bit per enabled clock, MSB-first or LSB-first, so that a receiver shifting in the same direction reassembles the word unchanged. It sits between the word-level datapath and the single-wire serial link.

Parameters:
n, 4, word width in bits; must be >= 2.

Ports:
clk  input  1  rising-edge clock; the only clock.
rst  input  1  asynchronous, active-high reset.
load_valid  input  1  producer offers a word on din/dir.
load_ready  output  1  block can accept a word this cycle (combinational).
din  input  n  parallel word to transmit.
dir  input  1  0 = MSB first, 1 = LSB first; sampled only at accept.
shift_en  input  1  1 = consume the current bit at this edge; 0 = stall.
sout  output  1  current serial bit.
sout_valid  output  1  sout carries a frame bit.
done  output  1  one-cycle pulse after the last bit of a frame is consumed.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (rst).
- Internal registers:
  - st: IDLE or SHIFT.
  - shreg[n-1:0]: shift register.
  - dir_q: latched direction.
  - cnt: clog2(n) bits.
  - done: registered pulse.
- Reset, asserted at any time including mid-frame: immediately st=IDLE, shreg=0, dir_q=0, cnt=0, done=0. The in-flight frame is discarded; no partial done.
- Outputs during reset: sout=0, sout_valid=0, load_ready=0 while rst=1.
- sout = dir_q ? shreg[0] : shreg[n-1] (combinational from registers).
- sout_valid = (st==SHIFT).
- load_ready = !rst && ((st==IDLE) || (st==SHIFT && shift_en && cnt==n-1)).
- Accept means load_valid && load_ready at a rising edge. On accept: shreg<=din, dir_q<=dir, cnt<=0, st<=SHIFT.
- Latency: the first bit appears on sout in the cycle after the accept edge.
- Consume means st==SHIFT && shift_en at a rising edge:
  - If cnt<n-1: cnt<=cnt+1.
    - dir_q=0: shreg<={shreg[n-2:0],1'b0}.
    - dir_q=1: shreg<={1'b0,shreg[n-1:1]}.
  - If cnt==n-1 (last bit):
    - done<=1.
    - If load_valid: accept the new word (back-to-back frame; st stays SHIFT; no gap in sout_valid).
    - Else: st<=IDLE, shreg<=0, cnt<=0.
- Stall: st==SHIFT && !shift_en means shreg, cnt and st hold. sout and sout_valid stay stable. load_valid is ignored, because load_ready=0.
- done<=0 on every edge that does not consume a last bit. A frame therefore produces exactly one done pulse, in the cycle after its last consume edge.
- Frame length is exactly n consume edges. A frame occupies n cycles of sout_valid when shift_en is held high.
- din and dir changes outside accept edges have no effect. dir can differ between back-to-back frames.
- In IDLE with load_valid=0, all state holds, sout=0 and done=0 (after any pending pulse).
- Synthesis notes: no latches; every register has the asynchronous reset; no combinational path from din to sout.

Test Plan:
1. n=4, din=4'b1011, dir=0, shift_en=1, single load_valid pulse -> sout=1,0,1,1 over 4 cycles, sout_valid high exactly 4 cycles, done high in cycle 5 only, load_ready back to 1.
2. Same word with dir=1 -> sout=1,1,0,1; done once in cycle 5.
3. Back-to-back: load_valid held with 4'b1011 (dir=0) then 4'b0110 (dir=1) -> sout=1,0,1,1,0,1,1,0 contiguous, sout_valid never drops over 8 cycles, done pulses in cycles 5 and 9, load_ready high only in IDLE and in the last-bit cycle of each frame.
4. Stall: 4'b1011, dir=0, shift_en=0 for 3 cycles after the 2nd bit is consumed -> sout holds 1 (3rd bit) for 4 cycles, sout_valid stays 1, load_valid ignored, done delayed to cycle 8.
5. Reset mid-frame: assert rst asynchronously after 2 bits of 4'b1011 -> sout, sout_valid, done and load_ready go 0 at once, with no done pulse. After release, load 4'b0101 with dir=0 -> sout=0,1,0,1 normally.

Source files
------------

// File: rtl/piso_bidir_serializer.sv
// Parallel-in, serial-out transmitter with per-word shift direction.
// Accepts an n-bit word over valid/ready, then emits one bit per enabled
// clock, MSB-first (dir=0) or LSB-first (dir=1). Back-to-back frames are
// accepted in the last-bit cycle so sout_valid has no gap between them.
module piso_bidir_serializer #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [n-1:0] din,
    input  logic         dir,
    input  logic         shift_en,
    output logic         sout,
    output logic         sout_valid,
    output logic         done
);

    localparam int CW = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] LAST = CW'(n - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } st_t;

    st_t           st;
    logic [n-1:0]  shreg;
    logic          dir_q;
    logic [CW-1:0] cnt;

    logic last_bit;
    logic accept;

    // Last-bit cycle: the current bit is consumed at this edge and ends the frame.
    assign last_bit   = (st == SHIFT) && shift_en && (cnt == LAST);
    // Ready only when idle or when the frame's last bit leaves this edge.
    assign load_ready = !rst && ((st == IDLE) || last_bit);
    assign accept     = load_valid && load_ready;

    // Serial outputs come straight from registers; no path from din.
    assign sout       = dir_q ? shreg[0] : shreg[n-1];
    assign sout_valid = (st == SHIFT);

    // Frame FSM: accept, shift, stall, back-to-back reload and done pulse.
    // NOTE: every register here uses <= so all updates see pre-edge values;
    // blocking assignments would let later statements read half-updated state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= IDLE;
            shreg <= '0;
            dir_q <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                IDLE: begin
                    if (accept) begin
                        shreg <= din;
                        dir_q <= dir;
                        cnt   <= '0;
                        st    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (shift_en) begin
                        if (cnt != LAST) begin
                            cnt <= cnt + CW'(1);
                            if (dir_q) begin
                                shreg <= {1'b0, shreg[n-1:1]};
                            end else begin
                                shreg <= {shreg[n-2:0], 1'b0};
                            end
                        end else begin
                            done <= 1'b1;
                            if (accept) begin
                                shreg <= din;
                                dir_q <= dir;
                                cnt   <= '0;
                                st    <= SHIFT;
                            end else begin
                                shreg <= '0;
                                cnt   <= '0;
                                st    <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    st <= IDLE;
                end
            endcase
        end
    end

endmodule
